// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its skid buffer.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INCR   = 32'd4;

  // 32-bit add, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_INCR;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer that parks an instruction word while IF/ID is stalled.
module if_skid_buf
  import if_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        drop,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] data,
  output logic        full
);

  // NOTE: sequential state is written only with non-blocking (<=) assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full <= 1'b0;
      // NOTE: the full flag alone marks validity; the data word is reset to a NOP only
      // so it never holds X, not because anything reads it while empty.
      data <= NOP_INSTR;
    end else if (drop) begin
      full <= 1'b0;
    end else if (load) begin
      data <= din;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: single outstanding imem request, IF/ID register, redirect kill.
// Optional macro IF_STALL_COUNT_EN adds a saturating 16-bit stall_count output.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifid_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef IF_STALL_COUNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  fetch_state_t state, state_next;

  logic [31:0] pc, pc_next, req_addr, ifid_load_instr;
  logic        pending, kill, kill_next, rsp_hit;
  logic        issue_req, ifid_load, ifid_bubble;
  logic        skid_load, skid_drop, skid_pop, skid_full;
  logic [31:0] skid_data;

  // A strobe only counts if it answers the request we still have open.
  assign rsp_hit = imem_rvalid && pending;

  always_ff @(posedge clk) begin
    if (!reset) state <= BOOT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (!redirect_valid && rsp_hit && !kill && ifid_stall) state_next = HOLD;
      HOLD:    if (redirect_valid || (!ifid_stall && skid_full)) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    issue_req       = 1'b0;
    req_addr        = pc;
    pc_next         = pc;
    kill_next       = kill;
    ifid_load       = 1'b0;
    ifid_bubble     = 1'b0;
    ifid_load_instr = imem_rdata;
    skid_load       = 1'b0;
    skid_drop       = 1'b0;
    skid_pop        = 1'b0;
    if (state == BOOT) begin
      issue_req = 1'b1;
      req_addr  = RESET_PC;
      pc_next   = RESET_PC;
      kill_next = 1'b0;
    end else if (redirect_valid) begin
      ifid_bubble = 1'b1;
      skid_drop   = 1'b1;
      pc_next     = redirect_pc;
      if (pending && !rsp_hit) begin
        kill_next = 1'b1;
      end else begin
        issue_req = 1'b1;
        req_addr  = redirect_pc;
        kill_next = 1'b0;
      end
    end else if (state == RUN) begin
      if (rsp_hit && kill) begin
        // Stale response from before the redirect: drop it and fetch the target now.
        issue_req = 1'b1;
        kill_next = 1'b0;
      end else if (rsp_hit && !ifid_stall) begin
        ifid_load = 1'b1;
        pc_next   = pc_plus4(pc);
        issue_req = 1'b1;
        req_addr  = pc_plus4(pc);
      end else if (rsp_hit) begin
        skid_load = 1'b1;
      end else if (!ifid_stall) begin
        ifid_bubble = 1'b1;
      end
    end else if (!ifid_stall && skid_full) begin
      ifid_load       = 1'b1;
      ifid_load_instr = skid_data;
      skid_pop        = 1'b1;
      pc_next         = pc_plus4(pc);
      issue_req       = 1'b1;
      req_addr        = pc_plus4(pc);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= RESET_PC;
      pending    <= 1'b0;
      kill       <= 1'b0;
      imem_req   <= 1'b0;
      imem_addr  <= 32'h0;
      ifid_valid <= 1'b0;
      ifid_instr <= 32'h0;
      ifid_pc4   <= 32'h0;
    end else begin
      pc       <= pc_next;
      kill     <= kill_next;
      imem_req <= issue_req;
      if (issue_req)    pending <= 1'b1;
      else if (rsp_hit) pending <= 1'b0;
      if (issue_req) imem_addr <= req_addr;
      if (ifid_load) begin
        ifid_instr <= ifid_load_instr;
        ifid_pc4   <= pc_plus4(pc);
        ifid_valid <= 1'b1;
      end else if (ifid_bubble) begin
        ifid_valid <= 1'b0;
      end
    end
  end

  if_skid_buf u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .drop  (skid_drop),
    .pop   (skid_pop),
    .din   (imem_rdata),
    .data  (skid_data),
    .full  (skid_full)
  );

`ifdef IF_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset)                                    stall_count <= 16'h0;
    else if (ifid_stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end
`endif

endmodule
